ps2_rx_ctrl: RTL and testbench
==============================

# ps2_rx_ctrl

Receive controller for the PS/2 keyboard interface. It sits directly behind the two debouncers on the PS/2 clock and data lines. It detects falling edges of the debounced PS/2 clock and sequences an 11-bit frame (start, 8 data LSB-first, odd parity, stop) through a state machine. Each validated byte is delivered over a valid/ready handshake to the scan-code decoder, and parity, framing, timeout and overrun errors are flagged.

## Interface

- TIMEOUT, 50000: max system-clock cycles allowed between consecutive PS/2 falling edges inside a frame (1 ms at 50 MHz); timeout counter width = $clog2(TIMEOUT+1)
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- ps2_clk_deb  input  1  debounced PS/2 clock
- ps2_data_deb  input  1  debounced PS/2 data
- rx_ready  input  1  consumer accepts byte when high with rx_valid
- rx_data  output  8  received byte, stable while rx_valid
- rx_valid  output  1  byte available; held until accepted
- busy  output  1  high while state != IDLE
- parity_err  output  1  one-cycle pulse, odd-parity check failed
- frame_err  output  1  one-cycle pulse, stop bit sampled 0
- timeout_err  output  1  one-cycle pulse, frame aborted on timeout
- overrun  output  1  one-cycle pulse, good byte dropped because buffer full

## Operation

- Edge detect: clk_prev register (reset 0). fall = clk_prev & ~ps2_clk_deb. Reset value 0 prevents a false edge while the debouncer output settles from its reset value of 0.
- Data is sampled from ps2_data_deb in the same cycle fall is high.
- States: IDLE, DATA, PARITY, STOP.
  - IDLE: on fall with data=0 -> DATA, bit_cnt=0. On fall with data=1 -> stay; the edge is ignored silently.
  - DATA: on fall, shift data into shift[7] (right shift, LSB first) and increment bit_cnt. On the 8th bit (bit_cnt==7) -> PARITY.
  - PARITY: on fall, store par_ok = ^shift ^ data (1 = odd parity correct) -> STOP.
  - STOP, on fall, always -> IDLE:
    - data=1 and par_ok: deliver the byte.
    - data=1 and !par_ok: parity_err.
    - data=0: frame_err only (no parity_err, even if parity is bad).
- Timeout: to_cnt clears on every fall and in IDLE, and increments otherwise. In DATA, PARITY or STOP, when to_cnt == TIMEOUT-1 with no fall that cycle: -> IDLE, timeout_err pulse, partial byte discarded.
- Delivery:
  - rx_valid=0, or rx_valid=1 with rx_ready=1 in the same cycle: load rx_data and set rx_valid=1.
  - rx_valid=1 with rx_ready=0: byte dropped, rx_data unchanged, overrun pulse.
- Handshake: when rx_valid & rx_ready with no simultaneous delivery, rx_valid clears next cycle. rx_ready is ignored while rx_valid=0.
- Error pulses never coincide with a delivery. At most one error pulse fires per cycle.

## Timing

- Reset (async, immediate): state=IDLE, clk_prev=0, shift=0, bit_cnt=0, to_cnt=0, rx_data=0x00, rx_valid=0, busy=0, all error pulses 0.
- Reset mid-frame aborts the frame with no error pulse. The first fall after release is treated as a potential start bit.
- Let N be the cycle in which fall for the stop bit is high. rx_valid rises at N+1, or the error/overrun pulse is high during N+1 only.
- busy rises the cycle after the start-bit fall and falls the cycle after the stop-bit fall or the timeout.
- timeout_err is high exactly TIMEOUT cycles after the last fall; it is the same cycle busy drops.
- Minimum fall spacing supported: 2 clk cycles. No fall is lost, including on the cycle rx_valid is accepted.
- Byte throughput: at most one delivery per frame; the buffer is one entry deep.

## Test plan

- Valid frame 0x1C: bits 0, 0,0,1,1,1,0,0,0, parity 0, stop 1, rx_ready=0 -> rx_valid=1 one cycle after stop fall, rx_data=0x1C held. Assert rx_ready for one cycle -> rx_valid=0 next cycle, no error pulses.
- Parity error: frame 0x1C with parity bit 1 -> parity_err one-cycle pulse, rx_valid stays 0, busy=0 afterwards.
- Stop error: frame 0xF0 (parity 1) with stop bit 0 -> frame_err pulse only, no rx_valid.
- Timeout with TIMEOUT=100: start plus 5 data bits, then clock held high -> timeout_err exactly 100 cycles after last fall, busy=0. A following valid 0xF0 frame -> rx_data=0xF0, rx_valid=1.
- Overrun: frames 0x1C then 0x32 (parity 0) with rx_ready=0 -> rx_data=0x1C, overrun pulse after second stop. Repeat with rx_ready=1 exactly in the second stop's delivery cycle -> rx_data=0x32, rx_valid stays 1, no overrun.
- Reset mid-frame: rst_n low after 4 data bits -> all outputs 0 immediately. After release, a full 0x1C frame -> rx_data=0x1C, no spurious error pulses.

Source files
------------

// File: rtl/ps2_rx_ctrl.sv
// ----------------------------------------------------------------------------
// ps2_rx_ctrl
//
// PS/2 keyboard receive controller. It sits behind the clock/data debouncers,
// detects falling edges of the debounced PS/2 clock and walks an 11-bit frame
// (start, 8 data bits LSB first, odd parity, stop) through a small FSM.
// Good bytes go to a one-entry buffer that is drained through a valid/ready
// handshake. Parity, framing, timeout and overrun conditions are reported as
// one-cycle registered pulses, and no two of them can fire in the same cycle.
// ----------------------------------------------------------------------------
module ps2_rx_ctrl #(
    parameter int TIMEOUT = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk_deb,
    input  logic       ps2_data_deb,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       parity_err,
    output logic       frame_err,
    output logic       timeout_err,
    output logic       overrun
);

    localparam int              TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0] TO_ZERO = TO_W'(0);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // Odd parity holds when the 8 data bits plus the parity bit contain an
    // odd number of ones, i.e. their XOR reduction is 1.
    function automatic logic odd_parity_ok(input logic [7:0] data_byte,
                                           input logic       parity_bit);
        return (^data_byte) ^ parity_bit;
    endfunction

    // ------------------------------------------------------------------
    // Registers and their next-state values
    // ------------------------------------------------------------------
    state_t          state_r;
    state_t          state_nx_s;
    logic            clk_prev_r;
    logic [7:0]      shift_r;
    logic [7:0]      shift_nx_s;
    logic [2:0]      bit_cnt_r;
    logic [2:0]      bit_cnt_nx_s;
    logic [TO_W-1:0] to_cnt_r;
    logic [TO_W-1:0] to_cnt_nx_s;
    logic            par_ok_r;
    logic            par_ok_nx_s;

    logic [7:0]      rx_data_r;
    logic [7:0]      rx_data_nx_s;
    logic            rx_valid_r;
    logic            rx_valid_nx_s;
    logic            busy_r;
    logic            parity_err_r;
    logic            frame_err_r;
    logic            timeout_err_r;
    logic            overrun_r;
    logic            overrun_nx_s;

    // Frame-level events decided in the stop/timeout cycle
    logic            fall_s;
    logic            to_expire_s;
    logic            good_byte_s;
    logic            par_bad_s;
    logic            stop_bad_s;

    // A falling edge is only seen once clk_prev has captured a 1, so the
    // debouncer settling out of its own reset cannot fake a start bit.
    assign fall_s = clk_prev_r & ~ps2_clk_deb;

    // The frame is abandoned when the inter-edge gap reaches TIMEOUT cycles;
    // a fall in that same cycle wins and keeps the frame alive.
    assign to_expire_s = (state_r != IDLE) && !fall_s && (to_cnt_r == TO_LAST);

    // Next-state, shift register, bit counter and end-of-frame decisions
    always_comb begin
        state_nx_s   = state_r;
        shift_nx_s   = shift_r;
        bit_cnt_nx_s = bit_cnt_r;
        par_ok_nx_s  = par_ok_r;
        good_byte_s  = 1'b0;
        par_bad_s    = 1'b0;
        stop_bad_s   = 1'b0;

        case (state_r)
            IDLE: begin
                // A fall with data high is not a start bit and is dropped.
                if (fall_s && !ps2_data_deb) begin
                    state_nx_s   = DATA;
                    bit_cnt_nx_s = 3'd0;
                end else begin
                    state_nx_s   = IDLE;
                end
            end

            DATA: begin
                if (fall_s) begin
                    shift_nx_s   = {ps2_data_deb, shift_r[7:1]};
                    bit_cnt_nx_s = bit_cnt_r + 3'd1;
                    if (bit_cnt_r == 3'd7) begin
                        state_nx_s = PARITY;
                    end else begin
                        state_nx_s = DATA;
                    end
                end else if (to_expire_s) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = DATA;
                end
            end

            PARITY: begin
                if (fall_s) begin
                    par_ok_nx_s = odd_parity_ok(shift_r, ps2_data_deb);
                    state_nx_s  = STOP;
                end else if (to_expire_s) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = PARITY;
                end
            end

            STOP: begin
                if (fall_s) begin
                    state_nx_s = IDLE;
                    // A bad stop bit is reported alone, regardless of parity.
                    if (!ps2_data_deb) begin
                        stop_bad_s = 1'b1;
                    end else if (par_ok_r) begin
                        good_byte_s = 1'b1;
                    end else begin
                        par_bad_s = 1'b1;
                    end
                end else if (to_expire_s) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = STOP;
                end
            end

            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Inter-edge gap counter: held at zero while idle and on every fall
    always_comb begin
        if ((state_r == IDLE) || fall_s) begin
            to_cnt_nx_s = TO_ZERO;
        end else begin
            to_cnt_nx_s = to_cnt_r + TO_ONE;
        end
    end

    // One-entry output buffer: load when empty or draining this cycle,
    // otherwise drop the new byte and flag overrun
    always_comb begin
        rx_data_nx_s  = rx_data_r;
        rx_valid_nx_s = rx_valid_r;
        overrun_nx_s  = 1'b0;

        if (good_byte_s) begin
            if (!rx_valid_r || rx_ready) begin
                rx_data_nx_s  = shift_r;
                rx_valid_nx_s = 1'b1;
            end else begin
                overrun_nx_s  = 1'b1;
            end
        end else if (rx_valid_r && rx_ready) begin
            rx_valid_nx_s = 1'b0;
        end else begin
            rx_valid_nx_s = rx_valid_r;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Receive datapath: clock-edge history, shift register, counters, parity
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_prev_r <= 1'b0;
            shift_r    <= 8'h00;
            bit_cnt_r  <= 3'd0;
            to_cnt_r   <= TO_ZERO;
            par_ok_r   <= 1'b0;
        end else begin
            clk_prev_r <= ps2_clk_deb;
            shift_r    <= shift_nx_s;
            bit_cnt_r  <= bit_cnt_nx_s;
            to_cnt_r   <= to_cnt_nx_s;
            par_ok_r   <= par_ok_nx_s;
        end
    end

    // Registered outputs: buffer, busy flag and one-cycle status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data_r     <= 8'h00;
            rx_valid_r    <= 1'b0;
            busy_r        <= 1'b0;
            parity_err_r  <= 1'b0;
            frame_err_r   <= 1'b0;
            timeout_err_r <= 1'b0;
            overrun_r     <= 1'b0;
        end else begin
            rx_data_r     <= rx_data_nx_s;
            rx_valid_r    <= rx_valid_nx_s;
            busy_r        <= (state_nx_s != IDLE);
            parity_err_r  <= par_bad_s;
            frame_err_r   <= stop_bad_s;
            timeout_err_r <= to_expire_s;
            overrun_r     <= overrun_nx_s;
        end
    end

    assign rx_data     = rx_data_r;
    assign rx_valid    = rx_valid_r;
    assign busy        = busy_r;
    assign parity_err  = parity_err_r;
    assign frame_err   = frame_err_r;
    assign timeout_err = timeout_err_r;
    assign overrun     = overrun_r;

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ps2_rx_ctrl
//
// Directed bench for ps2_rx_ctrl with TIMEOUT = 100. A frame-level model
// collects the sampled bits of each frame, judges it as a whole (byte value,
// parity by counting ones, stop bit, gap length) and predicts every output for
// the next cycle; the compare process checks the DUT against it on every
// falling clk edge. Literal expectations at key points pin the model itself.
// ----------------------------------------------------------------------------
module tb_ps2_rx_ctrl;

    localparam int TIMEOUT = 100;

    logic       clk          = 1'b0;
    logic       rst_n        = 1'b1;
    logic       ps2_clk_deb  = 1'b1;
    logic       ps2_data_deb = 1'b1;
    logic       rx_ready     = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       parity_err;
    logic       frame_err;
    logic       timeout_err;
    logic       overrun;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    int n_par = 0;
    int n_frm = 0;
    int n_to  = 0;
    int n_ovr = 0;

    ps2_rx_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ps2_clk_deb  (ps2_clk_deb),
        .ps2_data_deb (ps2_data_deb),
        .rx_ready     (rx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .busy         (busy),
        .parity_err   (parity_err),
        .frame_err    (frame_err),
        .timeout_err  (timeout_err),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h, expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    logic       m_prev     = 1'b0;
    logic       m_fall;
    bit         m_in_frame = 1'b0;
    int         m_nbits    = 0;
    int         m_since    = 0;
    logic [9:0] m_bits     = 10'd0;
    logic [7:0] m_byte;
    bit         m_dlv;
    logic [7:0] e_data  = 8'h00;
    logic       e_valid = 1'b0;
    logic       e_busy  = 1'b0;
    logic       e_par   = 1'b0;
    logic       e_frm   = 1'b0;
    logic       e_to    = 1'b0;
    logic       e_ovr   = 1'b0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_prev = 1'b0; m_in_frame = 1'b0; m_nbits = 0; m_since = 0;
                e_data = 8'h00; e_valid = 1'b0; e_busy = 1'b0;
                e_par = 1'b0; e_frm = 1'b0; e_to = 1'b0; e_ovr = 1'b0;
            end else begin
                m_fall = m_prev && !ps2_clk_deb;
                m_prev = ps2_clk_deb;
                e_par = 1'b0; e_frm = 1'b0; e_to = 1'b0; e_ovr = 1'b0;
                m_dlv = 1'b0;
                if (m_fall) begin
                    m_since = 0;
                    if (!m_in_frame) begin
                        if (!ps2_data_deb) begin
                            m_in_frame = 1'b1;
                            m_nbits    = 0;
                        end
                    end else begin
                        m_bits[m_nbits] = ps2_data_deb;
                        m_nbits++;
                        if (m_nbits == 10) begin
                            m_in_frame = 1'b0;
                            m_byte = m_bits[7:0];
                            if (!m_bits[9])
                                e_frm = 1'b1;
                            else if (($countones({m_byte, m_bits[8]}) % 2) == 1)
                                m_dlv = 1'b1;
                            else
                                e_par = 1'b1;
                        end
                    end
                end else if (m_in_frame) begin
                    m_since++;
                    if (m_since == TIMEOUT) begin
                        m_in_frame = 1'b0;
                        e_to = 1'b1;
                    end
                end
                if (m_dlv) begin
                    if (!e_valid || rx_ready) begin
                        e_valid = 1'b1;
                        e_data  = m_byte;
                    end else begin
                        e_ovr = 1'b1;
                    end
                end else if (e_valid && rx_ready) begin
                    e_valid = 1'b0;
                end
                e_busy = m_in_frame;
            end
        end
    end

    // Per-cycle comparison against the model plus pulse tallies
    always @(negedge clk) begin
        if (chk_en) begin
            chk8("rx_data",     rx_data,     e_data);
            chk1("rx_valid",    rx_valid,    e_valid);
            chk1("busy",        busy,        e_busy);
            chk1("parity_err",  parity_err,  e_par);
            chk1("frame_err",   frame_err,   e_frm);
            chk1("timeout_err", timeout_err, e_to);
            chk1("overrun",     overrun,     e_ovr);
        end
        if (parity_err === 1'b1)  n_par++;
        if (frame_err === 1'b1)   n_frm++;
        if (timeout_err === 1'b1) n_to++;
        if (overrun === 1'b1)     n_ovr++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bit_fall(input logic b);
        ps2_data_deb = b;
        cyc(3);
        ps2_clk_deb = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        bit_fall(b);
        cyc(3);
        ps2_clk_deb = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic p, input logic s,
                              input logic rdy_stop);
        logic [10:0] fr;
        fr = {s, p, b, 1'b0};
        for (int i = 0; i < 10; i++) send_bit(fr[i]);
        bit_fall(fr[10]);
        if (rdy_stop) begin
            rx_ready = 1'b1;
            cyc(1);
            rx_ready = 1'b0;
            cyc(2);
        end else begin
            cyc(3);
        end
        ps2_clk_deb  = 1'b1;
        ps2_data_deb = 1'b1;
        cyc(3);
    endtask

    task automatic ack();
        rx_ready = 1'b1;
        cyc(1);
        rx_ready = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        #2 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        chk1("reset_valid", rx_valid, 1'b0);
        chk1("reset_busy", busy, 1'b0);
        cyc(3);
        rst_n = 1'b1;
        cyc(3);

        // Fall with data high while idle is ignored
        send_bit(1'b1);
        cyc(2);
        chk1("stray_busy", busy, 1'b0);

        // Valid 0x1C, held until accepted
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        chk1("f1c_valid", rx_valid, 1'b1);
        chk8("f1c_data", rx_data, 8'h1C);
        cyc(5);
        chk8("f1c_held", rx_data, 8'h1C);
        ack();
        chk1("ack_clears", rx_valid, 1'b0);
        chki("no_err_pulses", n_par + n_frm + n_to + n_ovr, 0);

        // Parity error
        send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
        chki("par_pulses", n_par, 1);
        chk1("par_no_valid", rx_valid, 1'b0);
        chk1("par_busy", busy, 1'b0);

        // Stop-bit error, parity good
        send_frame(8'hF0, 1'b1, 1'b0, 1'b0);
        chki("frm_pulses", n_frm, 1);
        chki("frm_no_par", n_par, 1);
        chk1("frm_no_valid", rx_valid, 1'b0);

        // Timeout: start + 5 data bits, then clock held high
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        bit_fall(1'b1);
        cyc(3);
        ps2_clk_deb = 1'b1;
        cyc(97);
        chk1("to_not_yet", timeout_err, 1'b0);
        chk1("to_busy_before", busy, 1'b1);
        cyc(1);
        chk1("to_pulse", timeout_err, 1'b1);
        chk1("to_busy_after", busy, 1'b0);
        cyc(1);
        chk1("to_one_cycle", timeout_err, 1'b0);
        send_frame(8'hF0, 1'b1, 1'b1, 1'b0);
        chk1("f0_valid", rx_valid, 1'b1);
        chk8("f0_data", rx_data, 8'hF0);
        chki("to_pulses", n_to, 1);

        // Overrun: second byte dropped while buffer full
        ack();
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        send_frame(8'h32, 1'b0, 1'b1, 1'b0);
        chk8("ovr_data", rx_data, 8'h1C);
        chk1("ovr_valid", rx_valid, 1'b1);
        chki("ovr_pulses", n_ovr, 1);

        // Accept coincides with the second delivery: no overrun
        ack();
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        send_frame(8'h32, 1'b0, 1'b1, 1'b1);
        chk8("swap_data", rx_data, 8'h32);
        chk1("swap_valid", rx_valid, 1'b1);
        chki("swap_no_ovr", n_ovr, 1);

        // Reset in the middle of a frame
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        rst_n = 1'b0;
        #1;
        chk1("rst_valid", rx_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk8("rst_data", rx_data, 8'h00);
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        chk8("post_rst_data", rx_data, 8'h1C);
        chk1("post_rst_valid", rx_valid, 1'b1);
        chki("post_rst_pulses", n_par + n_frm + n_to + n_ovr, 4);
        cyc(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
